// File: rtl/dma_io_peripheral.sv
// Single-channel DMA requester: DREQ/DACK handshake toward an 8237-style
// controller, transmit FIFO sourced onto the bus during IOR_N strobes, and
// receive FIFO filled from the bus on IOW_N strobes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | latch direction, wait for the request condition
// REQ   | DREQ high, waiting for DACK
// XFER  | DACK granted, waiting for a strobe completion
// DONE  | one cycle after a byte; re-enter XFER only in demand mode
module dma_io_peripheral #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int DEMAND_MODE = 0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  DIR,
    output logic                  DREQ,
    input  logic                  DACK,
    input  logic                  IOR_N,
    input  logic                  IOW_N,
    input  logic                  EOP_N,
    input  logic [DATA_WIDTH-1:0] DB_IN,
    output logic [DATA_WIDTH-1:0] DB_OUT,
    output logic                  DB_OE,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  snk_valid,
    output logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  snk_ready,
    input  logic                  tc_clr,
    output logic                  tc_seen,
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t                state;
    logic                  dir_q;
    logic                  strobe_low_q;
    logic [DATA_WIDTH-1:0] capture;

    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [AW-1:0]         tx_wr, tx_rd;
    logic [CW-1:0]         tx_count;
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]         rx_wr, rx_rd;
    logic [CW-1:0]         rx_count;

    logic strobe_n, completion, eop_evt;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic req_idle, req_cur;

    assign strobe_n   = dir_q ? IOW_N : IOR_N;
    assign completion = (state == XFER) && strobe_low_q && DACK && strobe_n;
    assign eop_evt    = !EOP_N && DACK;

    assign tx_push = src_valid && src_ready;
    assign tx_pop  = completion && !dir_q;
    assign rx_push = completion && dir_q;
    assign rx_pop  = snk_valid && snk_ready;

    // IDLE evaluates the condition with the live DIR, since dir_q is only
    // being loaded on that same edge.
    assign req_idle = !tc_seen && (DIR   ? (rx_count != FULL) : (tx_count != '0));
    assign req_cur  = !tc_seen && (dir_q ? (rx_count != FULL) : (tx_count != '0));

    assign src_ready = (tx_count != FULL);
    assign snk_valid = (rx_count != '0);
    assign snk_data  = rx_mem[rx_rd];
    assign DB_OE     = (state == XFER) && DACK && !IOR_N && !dir_q;
    assign DB_OUT    = DB_OE ? tx_mem[tx_rd] : '0;
    assign busy      = (state != IDLE);

    // Handshake FSM; DREQ is loaded with the decode of the state being entered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            dir_q <= 1'b0;
            DREQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dir_q <= DIR;
                    if (req_idle) begin
                        state <= REQ;
                        DREQ  <= 1'b1;
                    end else begin
                        DREQ  <= 1'b0;
                    end
                end
                REQ: begin
                    DREQ <= 1'b1;
                    if (DACK) state <= XFER;
                end
                XFER: begin
                    // An EOP earlier in the strobe still lets its byte finish here.
                    if (completion) begin
                        if (tc_seen || eop_evt) begin
                            state <= IDLE;
                            DREQ  <= 1'b0;
                        end else begin
                            state <= DONE;
                            DREQ  <= (DEMAND_MODE != 0);
                        end
                    end else if (!DACK) begin
                        state <= IDLE;
                        DREQ  <= 1'b0;
                    end else begin
                        DREQ  <= 1'b1;
                    end
                end
                DONE: begin
                    if ((DEMAND_MODE != 0) && req_cur && DACK && !eop_evt) begin
                        state <= XFER;
                        DREQ  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        DREQ  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    DREQ  <= 1'b0;
                end
            endcase
        end
    end

    // Strobe history for edge detection, and sticky terminal count (set wins).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strobe_low_q <= 1'b0;
            tc_seen      <= 1'b0;
        end else begin
            strobe_low_q <= DACK && !strobe_n;
            if (eop_evt)     tc_seen <= 1'b1;
            else if (tc_clr) tc_seen <= 1'b0;
        end
    end

    // Bus capture; the last low-strobe value is what gets pushed at completion.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                              capture <= '0;
        else if (state == XFER && DACK && !IOW_N)  capture <= DB_IN;
    end

    // FIFO storage arrays; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wr] <= src_data;
        if (rx_push) rx_mem[rx_wr] <= capture;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench: one single-mode and one demand-mode instance share the
// controller-side and local-side inputs; each test looks at one instance.
module tb_dma_io_peripheral;

    logic       CLK, RESET_N, DIR, DACK, IOR_N, IOW_N, EOP_N;
    logic [7:0] DB_IN, src_data;
    logic       src_valid, snk_ready, tc_clr;

    logic       s_dreq, s_db_oe, s_src_ready, s_snk_valid, s_tc_seen, s_busy;
    logic [7:0] s_db_out, s_snk_data;
    logic       d_dreq, d_db_oe, d_src_ready, d_snk_valid, d_tc_seen, d_busy;
    logic [7:0] d_db_out, d_snk_data;

    int vectors = 0;
    int miscompares = 0;

    dma_io_peripheral #(.DATA_WIDTH(8), .DEPTH(4), .DEMAND_MODE(0)) u_single (
        .CLK(CLK), .RESET_N(RESET_N), .DIR(DIR), .DREQ(s_dreq), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN),
        .DB_OUT(s_db_out), .DB_OE(s_db_oe), .src_valid(src_valid),
        .src_data(src_data), .src_ready(s_src_ready), .snk_valid(s_snk_valid),
        .snk_data(s_snk_data), .snk_ready(snk_ready), .tc_clr(tc_clr),
        .tc_seen(s_tc_seen), .busy(s_busy));

    dma_io_peripheral #(.DATA_WIDTH(8), .DEPTH(4), .DEMAND_MODE(1)) u_demand (
        .CLK(CLK), .RESET_N(RESET_N), .DIR(DIR), .DREQ(d_dreq), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN),
        .DB_OUT(d_db_out), .DB_OE(d_db_oe), .src_valid(src_valid),
        .src_data(src_data), .src_ready(d_src_ready), .snk_valid(d_snk_valid),
        .snk_data(d_snk_data), .snk_ready(snk_ready), .tc_clr(tc_clr),
        .tc_seen(d_tc_seen), .busy(d_busy));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic do_reset();
        RESET_N = 1'b0; DIR = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1;
        EOP_N = 1'b1; DB_IN = 8'h00; src_valid = 1'b0; src_data = 8'h00;
        snk_ready = 1'b0; tc_clr = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // One single-mode IOR_N byte on u_single, optionally pushing during the completion cycle.
    task automatic read_byte(input logic [7:0] exp, input bit do_push, input logic [7:0] push_val);
        int n = 0;
        while (s_dreq !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (s_dreq !== 1'b1) begin
            miscompares++;
            $display("FAIL read_wait_dreq: dreq=%b required 1 (byte %h)", s_dreq, exp);
        end
        DACK = 1'b1;
        @(negedge CLK);
        IOR_N = 1'b0;
        #1;
        vectors++;
        if (s_db_oe !== 1'b1 || s_db_out !== exp) begin
            miscompares++;
            $display("FAIL read_data: oe=%b out=%h required oe=1 out=%h", s_db_oe, s_db_out, exp);
        end
        @(negedge CLK);
        IOR_N = 1'b1;
        if (do_push) begin
            src_valid = 1'b1;
            src_data  = push_val;
        end
        @(negedge CLK);
        src_valid = 1'b0;
        DACK = 1'b0;
        vectors++;
        if (s_dreq !== 1'b0 || s_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_done: dreq=%b busy=%b required dreq=0 busy=1", s_dreq, s_busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            vectors++;
            if ({s_dreq, s_src_ready, s_snk_valid, s_db_oe, s_tc_seen, s_busy} !== 6'b010000 ||
                {d_dreq, d_src_ready, d_snk_valid, d_db_oe, d_tc_seen, d_busy} !== 6'b010000 ||
                s_db_out !== 8'h00 || d_db_out !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d: s=%b d=%b required 010000", i,
                         {s_dreq, s_src_ready, s_snk_valid, s_db_oe, s_tc_seen, s_busy},
                         {d_dreq, d_src_ready, d_snk_valid, d_db_oe, d_tc_seen, d_busy});
            end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        src_valid = 1'b1; src_data = 8'hA5;
        @(negedge CLK);
        src_valid = 1'b0;
        vectors++;
        if (s_dreq !== 1'b0) begin
            miscompares++;
            $display("FAIL single_dreq_early: dreq=%b required 0", s_dreq);
        end
        @(negedge CLK);
        vectors++;
        if (s_dreq !== 1'b1 || s_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_dreq_rise: dreq=%b busy=%b required 1 1", s_dreq, s_busy);
        end
        DACK = 1'b1;
        @(negedge CLK);
        IOR_N = 1'b0;
        #1;
        vectors++;
        if (s_db_oe !== 1'b1 || s_db_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_db_first: oe=%b out=%h required 1 a5", s_db_oe, s_db_out);
        end
        @(negedge CLK);
        vectors++;
        if (s_db_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_db_second: out=%h required a5", s_db_out);
        end
        @(negedge CLK);
        IOR_N = 1'b1;
        #1;
        vectors++;
        if (s_db_oe !== 1'b0 || s_db_out !== 8'h00) begin
            miscompares++;
            $display("FAIL single_db_release: oe=%b out=%h required 0 00", s_db_oe, s_db_out);
        end
        @(negedge CLK);
        DACK = 1'b0;
        vectors++;
        if (s_dreq !== 1'b0 || s_busy !== 1'b1 || s_src_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done: dreq=%b busy=%b rdy=%b required 0 1 1", s_dreq, s_busy, s_src_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            vectors++;
            if (s_dreq !== 1'b0 || s_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL single_after: dreq=%b busy=%b required 0 0", s_dreq, s_busy);
            end
        end
    endtask

    task automatic test_demand_write();
        logic [7:0] data [4];
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
        do_reset();
        DIR = 1'b1;
        @(negedge CLK);
        vectors++;
        if (d_dreq !== 1'b1) begin
            miscompares++;
            $display("FAIL demand_dreq_rise: dreq=%b required 1", d_dreq);
        end
        DACK = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            IOW_N = 1'b0; DB_IN = data[k];
            @(negedge CLK);
            IOW_N = 1'b1; DB_IN = 8'hFF;
            @(negedge CLK);
            vectors++;
            if (d_dreq !== 1'b1) begin
                miscompares++;
                $display("FAIL demand_hold_done byte %0d: dreq=%b required 1", k, d_dreq);
            end
            @(negedge CLK);
            vectors++;
            if (k < 3) begin
                if (d_dreq !== 1'b1 || d_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL demand_hold_xfer byte %0d: dreq=%b busy=%b required 1 1", k, d_dreq, d_busy);
                end
            end else begin
                if (d_dreq !== 1'b0 || d_busy !== 1'b0 || d_snk_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL demand_full_drop: dreq=%b busy=%b snk_valid=%b required 0 0 1", d_dreq, d_busy, d_snk_valid);
                end
            end
        end
        DACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (d_dreq !== 1'b0) begin
                miscompares++;
                $display("FAIL demand_full_hold: dreq=%b required 0", d_dreq);
            end
        end
        snk_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (d_snk_valid !== 1'b1 || d_snk_data !== data[k]) begin
                miscompares++;
                $display("FAIL demand_drain %0d: valid=%b data=%h required 1 %h", k, d_snk_valid, d_snk_data, data[k]);
            end
            @(negedge CLK);
        end
        snk_ready = 1'b0;
        vectors++;
        if (d_snk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL demand_drain_empty: valid=%b required 0", d_snk_valid);
        end
    endtask

    task automatic test_wrap_order();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1; src_data = 8'h10 + 8'(i);
            @(negedge CLK);
        end
        src_data = 8'hEE;
        vectors++;
        if (s_src_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_full: src_ready=%b required 0", s_src_ready);
        end
        @(negedge CLK);
        src_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            read_byte(8'h10 + 8'(i), (i >= 1 && i <= 8), 8'h13 + 8'(i));
            if (i >= 1 && i <= 8) begin
                vectors++;
                if (s_src_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wrap_simul_count %0d: src_ready=%b required 1", i, s_src_ready);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            vectors++;
            if (s_dreq !== 1'b0 || s_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_empty: dreq=%b busy=%b required 0 0", s_dreq, s_busy);
            end
        end
    endtask

    task automatic test_terminal_count();
        int n = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1; src_data = 8'h31 + 8'(i);
            @(negedge CLK);
        end
        src_valid = 1'b0;
        while (d_dreq !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (d_dreq !== 1'b1) begin
            miscompares++;
            $display("FAIL tc_wait_dreq: dreq=%b required 1", d_dreq);
        end
        DACK = 1'b1;
        @(negedge CLK);
        IOR_N = 1'b0;
        #1;
        vectors++;
        if (d_db_out !== 8'h31) begin
            miscompares++;
            $display("FAIL tc_byte1: out=%h required 31", d_db_out);
        end
        @(negedge CLK);
        IOR_N = 1'b1;
        @(negedge CLK);
        vectors++;
        if (d_dreq !== 1'b1) begin
            miscompares++;
            $display("FAIL tc_done1: dreq=%b required 1", d_dreq);
        end
        @(negedge CLK);
        IOR_N = 1'b0;
        #1;
        vectors++;
        if (d_db_out !== 8'h32) begin
            miscompares++;
            $display("FAIL tc_byte2: out=%h required 32", d_db_out);
        end
        @(negedge CLK);
        IOR_N = 1'b1; EOP_N = 1'b0;
        @(negedge CLK);
        EOP_N = 1'b1; DACK = 1'b0;
        vectors++;
        if (d_tc_seen !== 1'b1 || d_dreq !== 1'b0 || d_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tc_set: tc=%b dreq=%b busy=%b required 1 0 0", d_tc_seen, d_dreq, d_busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            vectors++;
            if (d_dreq !== 1'b0 || d_tc_seen !== 1'b1) begin
                miscompares++;
                $display("FAIL tc_block: dreq=%b tc=%b required 0 1", d_dreq, d_tc_seen);
            end
        end
        tc_clr = 1'b1;
        @(negedge CLK);
        tc_clr = 1'b0;
        vectors++;
        if (d_tc_seen !== 1'b0 || d_dreq !== 1'b0) begin
            miscompares++;
            $display("FAIL tc_clear: tc=%b dreq=%b required 0 0", d_tc_seen, d_dreq);
        end
        @(negedge CLK);
        vectors++;
        if (d_dreq !== 1'b1) begin
            miscompares++;
            $display("FAIL tc_rerequest: dreq=%b required 1", d_dreq);
        end
        DACK = 1'b1;
        @(negedge CLK);
        IOR_N = 1'b0;
        #1;
        vectors++;
        if (d_db_out !== 8'h33) begin
            miscompares++;
            $display("FAIL tc_byte3: out=%h required 33", d_db_out);
        end
        @(negedge CLK);
        IOR_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        DACK = 1'b0;
        vectors++;
        if (d_dreq !== 1'b0 || d_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tc_final_idle: dreq=%b busy=%b required 0 0", d_dreq, d_busy);
        end
    endtask

    task automatic test_dack_drop();
        int n = 0;
        do_reset();
        src_valid = 1'b1; src_data = 8'h5A;
        @(negedge CLK);
        src_valid = 1'b0;
        while (s_dreq !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        DACK = 1'b1;
        @(negedge CLK);
        vectors++;
        if (s_dreq !== 1'b1 || s_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_xfer: dreq=%b busy=%b required 1 1", s_dreq, s_busy);
        end
        DACK = 1'b0;
        @(negedge CLK);
        vectors++;
        if (s_dreq !== 1'b0 || s_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle: dreq=%b busy=%b required 0 0", s_dreq, s_busy);
        end
        @(negedge CLK);
        vectors++;
        if (s_dreq !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_rerise: dreq=%b required 1", s_dreq);
        end
        read_byte(8'h5A, 1'b0, 8'h00);
        repeat (3) @(negedge CLK);
        vectors++;
        if (s_dreq !== 1'b0 || s_src_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_empty: dreq=%b rdy=%b required 0 1", s_dreq, s_src_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_demand_write();
        test_wrap_order();
        test_terminal_count();
        test_dack_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
